multicycle_control_unit: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle combinational decoder. It accepts an instruction through a valid/ready handshake and latches it into an instruction register. It then sequences DECODE, EXEC, MEM and WB states and drives the ALU controls (op, binv, cin), the memory strobes (mrd, mwr) and register write (wr). A memory-acknowledge handshake with timeout, illegal-opcode trapping and a PC-increment pulse are added. It sits between the fetch path and the ALU/register-file/memory datapath.

---
 rtl/multicycle_control_unit.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer: IDLE -> DECODE -> EXEC -> [MEM] -> WB.
// Latches one instruction at a time and drives ALU, memory and write-back controls.
module multicycle_control_unit #(
    parameter int INSTR_W     = 16,
    parameter int OPC_LSB     = 8,
    parameter int OPC_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instruction,
    output logic               instr_ready,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] ir,
    output logic [1:0]         op,
    output logic               binv,
    output logic               cin,
    output logic               mrd,
    output logic               mwr,
    output logic               wr,
    output logic               pc_inc,
    output logic               busy,
    output logic               illegal,
    output logic               mem_err
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [1:0] {
        C_REG,
        C_LOAD,
        C_STORE
    } cls_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [OPC_W-1:0] opc;
    logic [1:0]       d_op;
    logic             d_binv;
    logic             d_cin;
    logic             d_legal;
    cls_t             d_cls;

    // ir is stable from DECODE to WB, so the decode can stay combinational
    always_comb begin
        opc     = ir[OPC_LSB +: OPC_W];
        d_op    = 2'd0;
        d_binv  = 1'b0;
        d_cin   = 1'b0;
        d_legal = 1'b0;
        d_cls   = C_REG;
        if ((opc >> 4) == '0) begin
            unique case (opc[3:0])
                4'b0000: begin
                    d_legal = 1'b1;
                    d_cls   = C_LOAD;
                end
                4'b0001: begin
                    d_op    = 2'd1;
                    d_legal = 1'b1;
                    d_cls   = C_STORE;
                end
                4'b0010: begin
                    d_op    = 2'd2;
                    d_legal = 1'b1;
                    d_cls   = C_LOAD;
                end
                4'b0101: begin
                    d_op    = 2'd2;
                    d_binv  = 1'b1;
                    d_cin   = 1'b1;
                    d_legal = 1'b1;
                    d_cls   = C_STORE;
                end
                4'b0110: begin
                    d_op    = 2'd3;
                    d_binv  = 1'b1;
                    d_cin   = 1'b1;
                    d_legal = 1'b1;
                    d_cls   = C_REG;
                end
                default: d_legal = 1'b0;
            endcase
        end
    end

    // Outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            cnt         <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            op          <= 2'd0;
            binv        <= 1'b0;
            cin         <= 1'b0;
            mrd         <= 1'b0;
            mwr         <= 1'b0;
            wr          <= 1'b0;
            pc_inc      <= 1'b0;
            illegal     <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            illegal <= 1'b0;
            mem_err <= 1'b0;
            wr      <= 1'b0;
            pc_inc  <= 1'b0;
            mrd     <= 1'b0;
            mwr     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir          <= instruction;
                        state       <= S_DECODE;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (d_legal) begin
                        state <= S_EXEC;
                        op    <= d_op;
                        binv  <= d_binv;
                        cin   <= d_cin;
                    end else begin
                        state       <= S_IDLE;
                        illegal     <= 1'b1;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (d_cls == C_REG) begin
                        state  <= S_WB;
                        wr     <= 1'b1;
                        pc_inc <= 1'b1;
                    end else begin
                        state <= S_MEM;
                        cnt   <= '0;
                        mrd   <= (d_cls == C_LOAD);
                        mwr   <= (d_cls == C_STORE);
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        state  <= S_WB;
                        wr     <= 1'b1;
                        pc_inc <= 1'b1;
                    end else if (cnt == LAST) begin
                        state       <= S_IDLE;
                        mem_err     <= 1'b1;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        op          <= 2'd0;
                        binv        <= 1'b0;
                        cin         <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        mrd <= (d_cls == C_LOAD);
                        mwr <= (d_cls == C_STORE);
                    end
                end
                S_WB: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    op          <= 2'd0;
                    binv        <= 1'b0;
                    cin         <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    op          <= 2'd0;
                    binv        <= 1'b0;
                    cin         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MEM_TIMEOUT=4).
// Outputs are sampled on the falling edge; cycle n is the n-th cycle after the accept.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instruction;
    logic        instr_ready;
    logic        mem_ack;
    logic [15:0] ir;
    logic [1:0]  op;
    logic        binv, cin, mrd, mwr, wr, pc_inc, busy, illegal, mem_err;

    int compared = 0;
    int mismatched = 0;

    multicycle_control_unit #(
        .INSTR_W(16), .OPC_LSB(8), .OPC_W(4), .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid),
        .instruction(instruction), .instr_ready(instr_ready),
        .mem_ack(mem_ack), .ir(ir), .op(op), .binv(binv), .cin(cin),
        .mrd(mrd), .mwr(mwr), .wr(wr), .pc_inc(pc_inc), .busy(busy),
        .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // {instr_ready,busy,op,binv,cin,mrd,mwr,wr,pc_inc,illegal,mem_err}
    wire [11:0] obs = {instr_ready, busy, op, binv, cin,
                       mrd, mwr, wr, pc_inc, illegal, mem_err};
    localparam logic [11:0] IDLE_V = 12'b1000_0000_0000;

    task automatic start(input logic [15:0] ins);
        instruction = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b1;
        instruction = 16'h0200;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        instr_valid = 1'b0;
        compared++;
        if (obs !== IDLE_V) begin
            mismatched++;
            $display("FAIL reset_out: got %b need %b", obs, IDLE_V);
        end
        compared++;
        if (ir !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_ir: got %h need 0000", ir);
        end
        @(negedge clk);
        compared++;
        if (obs !== IDLE_V || ir !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_noaccept: got %b ir %h need %b ir 0000",
                     obs, ir, IDLE_V);
        end
    endtask

    task automatic test_add_load();
        logic [11:0] e;
        start(16'h0200);
        compared++;
        if (ir !== 16'h0200) begin
            mismatched++;
            $display("FAIL add_ir: got %h need 0200", ir);
        end
        for (int n = 1; n <= 7; n++) begin
            e = {n == 7, n < 7, (n >= 2 && n <= 6) ? 2'd2 : 2'd0,
                 1'b0, 1'b0, n >= 3 && n <= 5, 1'b0,
                 n == 6, n == 6, 1'b0, 1'b0};
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL add cyc%0d: got %b need %b", n, obs, e);
            end
            mem_ack = (n == 5);
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_slt_reg();
        logic [11:0] e;
        start(16'h0600);
        for (int n = 1; n <= 4; n++) begin
            e = {n == 4, n < 4, (n == 2 || n == 3) ? 2'd3 : 2'd0,
                 n == 2 || n == 3, n == 2 || n == 3, 1'b0, 1'b0,
                 n == 3, n == 3, 1'b0, 1'b0};
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL slt cyc%0d: got %b need %b", n, obs, e);
            end
            mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_illegal();
        logic [11:0] e;
        start(16'h0F00);
        for (int n = 1; n <= 3; n++) begin
            e = {n >= 2, n == 1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, n == 2, 1'b0};
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL illegal cyc%0d: got %b need %b", n, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sub_timeout();
        logic [11:0] e;
        logic        h;
        start(16'h0500);
        for (int n = 1; n <= 8; n++) begin
            h = (n >= 2 && n <= 6);
            e = {n >= 7, n < 7, h ? 2'd2 : 2'd0, h, h,
                 1'b0, n >= 3 && n <= 6, 1'b0, 1'b0, 1'b0, n == 7};
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL sub_to cyc%0d: got %b need %b", n, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sub_last_ack();
        logic [11:0] e;
        logic        h;
        start(16'h0500);
        for (int n = 1; n <= 8; n++) begin
            h = (n >= 2 && n <= 7);
            e = {n == 8, n < 8, h ? 2'd2 : 2'd0, h, h,
                 1'b0, n >= 3 && n <= 6, n == 7, n == 7, 1'b0, 1'b0};
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL sub_ack cyc%0d: got %b need %b", n, obs, e);
            end
            mem_ack = (n == 6);
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        logic [11:0] e;
        start(16'h0100);
        for (int n = 1; n <= 6; n++) begin
            if (n <= 4)
                e = {1'b0, 1'b1, n >= 2 ? 2'd1 : 2'd0, 1'b0, 1'b0,
                     1'b0, n >= 3, 1'b0, 1'b0, 1'b0, 1'b0};
            else
                e = IDLE_V;
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL rst_mem cyc%0d: got %b need %b", n, obs, e);
            end
            if (n >= 5) begin
                compared++;
                if (ir !== 16'h0000) begin
                    mismatched++;
                    $display("FAIL rst_mem_ir cyc%0d: got %h need 0000", n, ir);
                end
            end
            rst = (n == 4);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        start(16'h0600);
        for (int n = 1; n <= 3; n++) @(negedge clk);
        start(16'h0000);
        compared++;
        if (ir !== 16'h0000 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_accept: got ir %h busy %b need ir 0000 busy 1",
                     ir, busy);
        end
        for (int n = 2; n <= 5; n++) @(negedge clk);
        e = {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0};
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL b2b_and_mem: got %b need %b", obs, e);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        compared++;
        if (obs !== IDLE_V) begin
            mismatched++;
            $display("FAIL b2b_idle: got %b need %b", obs, IDLE_V);
        end
    endtask

    initial begin
        test_reset();
        test_add_load();
        test_slt_reg();
        test_illegal();
        test_sub_timeout();
        test_sub_last_ack();
        test_reset_mid_mem();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
